tpu_systolic_top: RTL and testbench

- 8x8 output-stationary systolic array that computes three independent 8x8 signed matrix products.
- Batches b = 0..2 are processed back-to-back, 8 cycles apart.
- Operands come from four external 128x32b SRAMs: weights in w0/w1, data in d0/d1.
- Results go, as anti-diagonals, to three external 16x128b SRAMs: a = batch0, b = batch1, c = batch2.

---
 rtl/tpu_systolic_top.sv | 225 ++++++++++++++++++++++
 tb/tb_tpu_systolic_top.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/tpu_systolic_top.sv
// 8x8 output-stationary systolic array: three back-to-back signed 8x8 matrix
// products, results streamed out as anti-diagonals to three write ports.
//
// state  | meaning
// S_IDLE | waiting for tpu_start, all SRAM ports quiet
// S_RUN  | streaming operands and writing diagonals, cnt = cycles since start
// S_DONE | tpu_done held until reset or the next tpu_start
module tpu_systolic_top #(
  parameter int ARRAY_SIZE      = 8,
  parameter int DATA_WIDTH      = 8,
  parameter int OUT_DATA_WIDTH  = 16,
  parameter int SRAM_DATA_WIDTH = 32
) (
  input  logic                                   clk,
  input  logic                                   srstn,
  input  logic                                   tpu_start,
  input  logic [SRAM_DATA_WIDTH-1:0]             sram_rdata_w0,
  input  logic [SRAM_DATA_WIDTH-1:0]             sram_rdata_w1,
  input  logic [SRAM_DATA_WIDTH-1:0]             sram_rdata_d0,
  input  logic [SRAM_DATA_WIDTH-1:0]             sram_rdata_d1,
  output logic [9:0]                             sram_raddr_w0,
  output logic [9:0]                             sram_raddr_w1,
  output logic [9:0]                             sram_raddr_d0,
  output logic [9:0]                             sram_raddr_d1,
  output logic                                   sram_write_enable_a0,
  output logic                                   sram_write_enable_b0,
  output logic                                   sram_write_enable_c0,
  output logic [ARRAY_SIZE*OUT_DATA_WIDTH-1:0]   sram_wdata_a,
  output logic [ARRAY_SIZE*OUT_DATA_WIDTH-1:0]   sram_wdata_b,
  output logic [ARRAY_SIZE*OUT_DATA_WIDTH-1:0]   sram_wdata_c,
  output logic [5:0]                             sram_waddr_a,
  output logic [5:0]                             sram_waddr_b,
  output logic [5:0]                             sram_waddr_c,
  output logic                                   tpu_done
);

  localparam int N     = ARRAY_SIZE;
  localparam int OW    = OUT_DATA_WIDTH;
  localparam int DW    = DATA_WIDTH;
  localparam int SW    = SRAM_DATA_WIDTH;
  localparam int LANES = SW / DW;
  localparam int WW    = N * OW;
  // Batch 2, diagonal 14 is written while cnt = 2*8 + 14 + 9.
  localparam logic [5:0] LAST_CYC = 6'd39;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

  state_t state, state_nxt;
  logic [5:0] cnt;
  logic       run;
  logic       rd_valid;

  logic [SW-1:0] w0_g, d0_g;
  logic [SW-1:0] w1_dly [4];
  logic [SW-1:0] d1_dly [4];

  logic signed [DW-1:0] w_row [N];
  logic signed [DW-1:0] d_col [N];
  logic signed [DW-1:0] w_in  [N][N];
  logic signed [DW-1:0] d_in  [N][N];
  logic signed [DW-1:0] w_reg [N][N];
  logic signed [DW-1:0] d_reg [N][N];
  logic [OW-1:0]        prod  [N][N];
  logic                 first [N][N];
  logic [OW-1:0]        acc   [N][N];
  logic [N*N-1:0][OW-1:0] acc_flat;

  logic       wact [3];
  logic [3:0] diag [3];

  always_ff @(posedge clk) begin
    if (srstn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (tpu_start) state_nxt = S_RUN;
      S_RUN:   if (cnt == LAST_CYC) state_nxt = S_DONE;
      S_DONE:  if (tpu_start) state_nxt = S_RUN;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign run      = (state == S_RUN);
  assign tpu_done = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (srstn) begin
      cnt      <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= run;
      if (!run && tpu_start)           cnt <= '0;
      else if (run && cnt != LAST_CYC) cnt <= cnt + 6'd1;
    end
  end

  assign sram_raddr_w0 = run ? {4'd0, cnt} : 10'd0;
  assign sram_raddr_w1 = run ? {4'd0, cnt} : 10'd0;
  assign sram_raddr_d0 = run ? {4'd0, cnt} : 10'd0;
  assign sram_raddr_d1 = run ? {4'd0, cnt} : 10'd0;

  // rdata is only meaningful one cycle into RUN; gating keeps stale words out.
  assign w0_g = rd_valid ? sram_rdata_w0 : '0;
  assign d0_g = rd_valid ? sram_rdata_d0 : '0;

  always_ff @(posedge clk) begin
    if (srstn) begin
      for (int k = 0; k < 4; k++) begin
        w1_dly[k] <= '0;
        d1_dly[k] <= '0;
      end
    end else begin
      w1_dly[0] <= rd_valid ? sram_rdata_w1 : '0;
      d1_dly[0] <= rd_valid ? sram_rdata_d1 : '0;
      for (int k = 1; k < 4; k++) begin
        w1_dly[k] <= w1_dly[k-1];
        d1_dly[k] <= d1_dly[k-1];
      end
    end
  end

  always_comb begin
    w_row = '{default: '0};
    d_col = '{default: '0};
    for (int r = 0; r < LANES; r++) begin
      w_row[r]         = w0_g[SW-1-DW*r -: DW];
      w_row[r+LANES]   = w1_dly[3][SW-1-DW*r -: DW];
      d_col[r]         = d0_g[SW-1-DW*r -: DW];
      d_col[r+LANES]   = d1_dly[3][SW-1-DW*r -: DW];
    end
  end

  always_comb begin
    logic [OW-1:0] w_ext, d_ext;
    logic [5:0]    ph;
    w_ext = '0;
    d_ext = '0;
    ph    = '0;
    w_in  = '{default: '0};
    d_in  = '{default: '0};
    prod  = '{default: '0};
    first = '{default: 1'b0};
    for (int i = 0; i < N; i++) begin
      w_in[i][0] = w_row[i];
      d_in[0][i] = d_col[i];
      for (int j = 1; j < N; j++) begin
        w_in[i][j] = w_reg[i][j-1];
        d_in[j][i] = d_reg[j-1][i];
      end
    end
    // k = 0 of each batch reaches PE(i,j) while cnt = 8b + i + j + 1.
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        w_ext       = {{(OW-DW){w_in[i][j][DW-1]}}, w_in[i][j]};
        d_ext       = {{(OW-DW){d_in[i][j][DW-1]}}, d_in[i][j]};
        prod[i][j]  = w_ext * d_ext;
        ph          = cnt - 6'(i + j + 1);
        first[i][j] = (cnt > 6'(i + j)) && (ph[2:0] == 3'd0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (srstn) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          w_reg[i][j] <= '0;
          d_reg[i][j] <= '0;
          acc[i][j]   <= '0;
        end
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          w_reg[i][j] <= w_in[i][j];
          d_reg[i][j] <= d_in[i][j];
          if (run) acc[i][j] <= first[i][j] ? prod[i][j] : acc[i][j] + prod[i][j];
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        acc_flat[i*N+j] = acc[i][j];
  end

  // Slot s of diagonal d holds PE(imax-s, d-imax+s), i.e. slot = imax - row.
  function automatic logic [WW-1:0] pack_diag(input logic [3:0] d,
                                               input logic [N*N-1:0][OW-1:0] a);
    logic [WW-1:0] w;
    int imax;
    w    = '0;
    imax = (int'(d) > N - 1) ? N - 1 : int'(d);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        if (i + j == int'(d)) w[WW-1-OW*(imax-i) -: OW] = a[i*N+j];
    return w;
  endfunction

  always_comb begin
    logic [5:0] base;
    base = '0;
    for (int b = 0; b < 3; b++) begin
      base    = 6'(8 * b + 9);
      wact[b] = run && (cnt >= base) && (cnt <= base + 6'd14);
      diag[b] = wact[b] ? 4'(cnt - base) : 4'd0;
    end
  end

  assign sram_write_enable_a0 = ~wact[0];
  assign sram_write_enable_b0 = ~wact[1];
  assign sram_write_enable_c0 = ~wact[2];
  assign sram_waddr_a = {2'b00, diag[0]};
  assign sram_waddr_b = {2'b00, diag[1]};
  assign sram_waddr_c = {2'b00, diag[2]};
  assign sram_wdata_a = wact[0] ? pack_diag(diag[0], acc_flat) : '0;
  assign sram_wdata_b = wact[1] ? pack_diag(diag[1], acc_flat) : '0;
  assign sram_wdata_c = wact[2] ? pack_diag(diag[2], acc_flat) : '0;

endmodule

// File: tb/tb_tpu_systolic_top.sv
// Bench for tpu_systolic_top: SRAM models around the DUT, random and corner
// operand sets compared against a plain matrix-product and packing model.
module tb_tpu_systolic_top;
  logic clk = 1'b0;
  logic srstn = 1'b1;
  logic tpu_start = 1'b0;
  logic [31:0] sram_rdata_w0 = '0, sram_rdata_w1 = '0, sram_rdata_d0 = '0, sram_rdata_d1 = '0;
  logic [9:0] sram_raddr_w0, sram_raddr_w1, sram_raddr_d0, sram_raddr_d1;
  logic sram_write_enable_a0, sram_write_enable_b0, sram_write_enable_c0;
  logic [127:0] sram_wdata_a, sram_wdata_b, sram_wdata_c;
  logic [5:0] sram_waddr_a, sram_waddr_b, sram_waddr_c;
  logic tpu_done;

  always #5 clk = ~clk;

  tpu_systolic_top dut (
    .clk(clk), .srstn(srstn), .tpu_start(tpu_start),
    .sram_rdata_w0(sram_rdata_w0), .sram_rdata_w1(sram_rdata_w1),
    .sram_rdata_d0(sram_rdata_d0), .sram_rdata_d1(sram_rdata_d1),
    .sram_raddr_w0(sram_raddr_w0), .sram_raddr_w1(sram_raddr_w1),
    .sram_raddr_d0(sram_raddr_d0), .sram_raddr_d1(sram_raddr_d1),
    .sram_write_enable_a0(sram_write_enable_a0),
    .sram_write_enable_b0(sram_write_enable_b0),
    .sram_write_enable_c0(sram_write_enable_c0),
    .sram_wdata_a(sram_wdata_a), .sram_wdata_b(sram_wdata_b), .sram_wdata_c(sram_wdata_c),
    .sram_waddr_a(sram_waddr_a), .sram_waddr_b(sram_waddr_b), .sram_waddr_c(sram_waddr_c),
    .tpu_done(tpu_done)
  );

  logic [31:0]  mem_w0 [128], mem_w1 [128], mem_d0 [128], mem_d1 [128];
  logic [127:0] mem_res [3][16];
  int           tot [3] = '{0, 0, 0};
  int           log_addr [3][512];
  logic signed [7:0] W [3][8][8];
  logic signed [7:0] D [3][8][8];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) begin
    sram_rdata_w0 <= (sram_raddr_w0 < 10'd128) ? mem_w0[sram_raddr_w0[6:0]] : '0;
    sram_rdata_w1 <= (sram_raddr_w1 < 10'd128) ? mem_w1[sram_raddr_w1[6:0]] : '0;
    sram_rdata_d0 <= (sram_raddr_d0 < 10'd128) ? mem_d0[sram_raddr_d0[6:0]] : '0;
    sram_rdata_d1 <= (sram_raddr_d1 < 10'd128) ? mem_d1[sram_raddr_d1[6:0]] : '0;
  end

  always @(posedge clk) begin
    if (!sram_write_enable_a0) begin
      mem_res[0][sram_waddr_a[3:0]] <= sram_wdata_a;
      if (tot[0] < 512) log_addr[0][tot[0]] <= int'(sram_waddr_a);
      tot[0] <= tot[0] + 1;
    end
    if (!sram_write_enable_b0) begin
      mem_res[1][sram_waddr_b[3:0]] <= sram_wdata_b;
      if (tot[1] < 512) log_addr[1][tot[1]] <= int'(sram_waddr_b);
      tot[1] <= tot[1] + 1;
    end
    if (!sram_write_enable_c0) begin
      mem_res[2][sram_waddr_c[3:0]] <= sram_wdata_c;
      if (tot[2] < 512) log_addr[2][tot[2]] <= int'(sram_waddr_c);
      tot[2] <= tot[2] + 1;
    end
  end

  // mode: 0 identity W / random D, 1 zeros, 2 all -128, 3 all 127, 4 random
  task automatic fill_operands(input int mode);
    for (int b = 0; b < 3; b++)
      for (int i = 0; i < 8; i++)
        for (int k = 0; k < 8; k++) begin
          case (mode)
            0: begin W[b][i][k] = (i == k) ? 8'sd1 : 8'sd0; D[b][i][k] = 8'($urandom); end
            1: begin W[b][i][k] = 8'sd0; D[b][i][k] = 8'sd0; end
            2: begin W[b][i][k] = -8'sd128; D[b][i][k] = -8'sd128; end
            3: begin W[b][i][k] = 8'sd127; D[b][i][k] = 8'sd127; end
            default: begin W[b][i][k] = 8'($urandom); D[b][i][k] = 8'($urandom); end
          endcase
        end
  endtask

  task automatic build_mems();
    int t, lane;
    for (int a = 0; a < 128; a++) begin
      mem_w0[a] = '0; mem_w1[a] = '0; mem_d0[a] = '0; mem_d1[a] = '0;
    end
    for (int b = 0; b < 3; b++)
      for (int r = 0; r < 8; r++)
        for (int k = 0; k < 8; k++) begin
          lane = r % 4;
          t    = 8 * b + k + lane;
          if (r < 4) begin
            mem_w0[t][31-8*lane -: 8] = W[b][r][k];
            mem_d0[t][31-8*lane -: 8] = D[b][r][k];
          end else begin
            mem_w1[t][31-8*lane -: 8] = W[b][r][k];
            mem_d1[t][31-8*lane -: 8] = D[b][r][k];
          end
        end
  endtask

  function automatic logic [15:0] cval(input int b, input int i, input int j);
    int s;
    s = 0;
    for (int k = 0; k < 8; k++) s += int'(W[b][i][k]) * int'(D[b][j][k]);
    return s[15:0];
  endfunction

  function automatic logic [127:0] exp_word(input int b, input int d);
    logic [127:0] w;
    int imax, n;
    w    = '0;
    imax = (d < 7) ? d : 7;
    n    = ((d < 14 - d) ? d : 14 - d) + 1;
    for (int s = 0; s < n; s++) w[127-16*s -: 16] = cval(b, imax - s, d - imax + s);
    return w;
  endfunction

  task automatic run_case(input int mode, input bit mid_start);
    int base [3];
    int cyc, bad;
    fill_operands(mode);
    build_mems();
    for (int x = 0; x < 3; x++) base[x] = tot[x];
    @(negedge clk) tpu_start = 1'b1;
    @(negedge clk) tpu_start = 1'b0;
    cyc = 0;
    while (!tpu_done && cyc < 60) begin
      @(negedge clk);
      cyc++;
      tpu_start = mid_start && (cyc == 10);
    end
    tpu_start = 1'b0;
    chk($sformatf("m%0d_done_latency cyc=%0d", mode, cyc), {127'd0, tpu_done && cyc <= 48}, 128'd1);
    repeat (3) @(negedge clk);
    chk($sformatf("m%0d_done_hold", mode), {127'd0, tpu_done}, 128'd1);
    for (int x = 0; x < 3; x++) begin
      chk($sformatf("m%0d_wr_count_%0d", mode, x), 128'(tot[x] - base[x]), 128'd15);
      bad = 0;
      for (int n = 0; n < 15; n++)
        if (base[x] + n >= 512 || log_addr[x][base[x] + n] != n) bad++;
      chk($sformatf("m%0d_wr_order_%0d", mode, x), 128'(bad), 128'd0);
      for (int d = 0; d < 15; d++)
        chk($sformatf("m%0d_b%0d_d%0d", mode, x, d), mem_res[x][d], exp_word(x, d));
    end
    if (mode == 3) chk("c127_slot", {112'd0, mem_res[1][7][127 -: 16]}, 128'hF808);
    if (mode == 2) chk("cneg128_slot", {112'd0, mem_res[2][7][127 -: 16]}, 128'h0);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_strobes"}, {125'd0, sram_write_enable_a0, sram_write_enable_b0, sram_write_enable_c0}, 128'd7);
    chk({tag, "_done"}, {127'd0, tpu_done}, 128'd0);
    chk({tag, "_raddr"}, {88'd0, sram_raddr_w0, sram_raddr_w1, sram_raddr_d0, sram_raddr_d1}, 128'd0);
    chk({tag, "_wdata"}, sram_wdata_a | sram_wdata_b | sram_wdata_c, 128'd0);
    chk({tag, "_waddr"}, {110'd0, sram_waddr_a, sram_waddr_b, sram_waddr_c}, 128'd0);
  endtask

  initial begin
    int idle_bad;
    int snap [3];
    srstn = 1'b1;
    repeat (3) @(negedge clk);
    chk_quiet("reset");
    srstn = 1'b0;

    idle_bad = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (!sram_write_enable_a0 || !sram_write_enable_b0 || !sram_write_enable_c0 || tpu_done)
        idle_bad++;
    end
    chk("idle_quiet", 128'(idle_bad), 128'd0);
    chk("idle_no_writes", 128'(tot[0] + tot[1] + tot[2]), 128'd0);

    run_case(0, 1'b0);
    run_case(1, 1'b0);
    run_case(2, 1'b0);
    run_case(3, 1'b0);
    run_case(4, 1'b1);

    fill_operands(4);
    build_mems();
    @(negedge clk) tpu_start = 1'b1;
    @(negedge clk) tpu_start = 1'b0;
    repeat (14) @(negedge clk);
    srstn = 1'b1;
    @(negedge clk);
    chk_quiet("midrun_reset");
    srstn = 1'b0;
    for (int x = 0; x < 3; x++) snap[x] = tot[x];
    repeat (60) @(negedge clk);
    for (int x = 0; x < 3; x++)
      chk($sformatf("abort_no_writes_%0d", x), 128'(tot[x] - snap[x]), 128'd0);
    chk("abort_no_done", {127'd0, tpu_done}, 128'd0);
    run_case(4, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
